// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALU/mux select codes,
// FSM state encodings and the packed control word.
package cpu_defs_pkg;

  localparam int unsigned StateW = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Encodings 12..15 are unused and recover to StFetch.
  typedef enum logic [StateW-1:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExec   = 4'd2,
    StRWb    = 4'd3,
    StMemAdr = 4'd4,
    StMemRd  = 4'd5,
    StMemWr  = 4'd6,
    StLwWb   = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multi_ctrl_decode.sv
// Combinational state -> control-word decode for the multi-cycle control FSM.
// Only FETCH's IR/PC loads and DECODE's illegal flag look at anything besides state.
module multi_ctrl_decode
  import cpu_defs_pkg::*;
(
  input  state_e     state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.illegal_op = ~is_legal_op(opcode);
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      StRWb: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      StMemAdr, StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StLwWb: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and next-state logic,
// with the control word produced by multi_ctrl_decode.
module multi_ctrl_fsm
  import cpu_defs_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         aluop,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OP_RTYPE:     state_d = StExec;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StAddiEx;
          default:      state_d = StFetch;
        endcase
      end
      StExec:   state_d = StRWb;
      StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
      StMemRd:  state_d = mem_ready ? StLwWb : StMemRd;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  multi_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign aluop         = ctrl.aluop;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state_o       = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// Self-checking bench for multi_ctrl_fsm: directed scenarios plus randomized instruction streams
// with memory stalls and stray resets, checked against per-opcode state paths.
module tb_multi_ctrl_fsm;
  import cpu_defs_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, aluop, pc_source;
  logic [3:0] state_o;
  logic [16:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_ctrl_fsm #(.STATE_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .aluop         (aluop),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state_o       (state_o)
  );

  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, aluop, pc_source, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control outputs, straight from the per-state output table.
  function automatic logic [16:0] exp_ctrl(state_e s, logic mr, logic [5:0] op);
    logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
    logic ill = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (s)
      StFetch:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      StDecode: begin
        sb = 2'b11;
        ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
      end
      StExec:   begin sa = 1; ao = 2'b10; end
      StRWb:    begin rd = 1; rw = 1; end
      StMemAdr: begin sa = 1; sb = 2'b10; end
      StMemRd:  begin mrd = 1; io = 1; end
      StMemWr:  begin mwr = 1; io = 1; end
      StLwWb:   begin m2r = 1; rw = 1; end
      StBranch: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      StJump:   begin pw = 1; ps = 2'b10; end
      StAddiEx: begin sa = 1; sb = 2'b10; end
      StAddiWb: begin rw = 1; end
      default: ;
    endcase
    return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
  endfunction

  // One clock: drive inputs, compare at the falling edge, then advance past the rising edge.
  task automatic step(input state_e s, input logic mr, input logic [5:0] op, input logic r);
    rst = r;
    mem_ready = mr;
    opcode = op;
    @(negedge clk);
    check($sformatf("state@%s", s.name()), 32'(state_o), 32'(s));
    check($sformatf("ctrl@%s", s.name()), 32'(obs), 32'(exp_ctrl(s, mr, op)));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int stall_pct, input int rst_pct);
    state_e path[$];
    logic mr, r;
    logic [5:0] o;
    int stalls;
    path = {StFetch, StDecode};
    case (op)
      OP_RTYPE: path = {path, StExec, StRWb};
      OP_LW:    path = {path, StMemAdr, StMemRd, StLwWb};
      OP_SW:    path = {path, StMemAdr, StMemWr};
      OP_BEQ:   path = {path, StBranch};
      OP_J:     path = {path, StJump};
      OP_ADDI:  path = {path, StAddiEx, StAddiWb};
      default: ;
    endcase
    foreach (path[i]) begin
      stalls = 0;
      forever begin
        mr = ($urandom_range(99) >= stall_pct) || (stalls >= 8);
        r  = ($urandom_range(99) < rst_pct);
        // Opcode is only meaningful in DECODE and MEM_ADR; scramble it elsewhere.
        o  = (path[i] == StDecode || path[i] == StMemAdr) ? op : 6'($urandom);
        step(path[i], mr, o, r);
        if (r) begin
          rst = 1'b0;
          return;
        end
        if (!mr && (path[i] inside {StFetch, StMemRd, StMemWr})) stalls++;
        else break;
      end
    end
  endtask

  task automatic latency(input logic [5:0] op, input int exp);
    int n = 0;
    rst = 1'b0;
    mem_ready = 1'b1;
    opcode = op;
    @(negedge clk);
    check("lat_start", 32'(state_o), 32'(StFetch));
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state_o != 4'(StFetch) && n < 20);
    check($sformatf("latency_%b", op), n, exp);
  endtask

  logic [5:0] legal_ops [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'(StFetch));
    check("rst_mem_read", 32'(mem_read), 32'd1);
    check("rst_aluop", 32'(aluop), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(OP_RTYPE, 0, 0);

    // lw with three slow-memory cycles in MEM_RD
    step(StFetch, 1, OP_LW, 0);
    step(StDecode, 1, OP_LW, 0);
    step(StMemAdr, 1, OP_LW, 0);
    repeat (3) step(StMemRd, 0, OP_LW, 0);
    step(StMemRd, 1, OP_LW, 0);
    step(StLwWb, 1, OP_LW, 0);

    run_instr(OP_BEQ, 0, 0);
    run_instr(6'b111111, 0, 0);

    // Reset while a store is stalled must abort it with no lingering write
    step(StFetch, 1, OP_SW, 0);
    step(StDecode, 1, OP_SW, 0);
    step(StMemAdr, 1, OP_SW, 0);
    step(StMemWr, 0, OP_SW, 0);
    step(StMemWr, 0, OP_SW, 1);
    step(StFetch, 0, OP_SW, 0);
    check("abort_mem_write", 32'(mem_write), 32'd0);
    step(StFetch, 1, OP_RTYPE, 0);
    step(StDecode, 1, OP_RTYPE, 0);
    step(StExec, 1, OP_RTYPE, 0);
    step(StRWb, 1, OP_RTYPE, 0);

    latency(OP_RTYPE, 4);
    latency(OP_LW, 5);
    latency(OP_SW, 4);
    latency(OP_BEQ, 3);
    latency(OP_J, 3);
    latency(OP_ADDI, 4);
    latency(6'b111111, 2);

    for (int k = 0; k < 400; k++) begin
      logic [5:0] op;
      if ($urandom_range(7) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(5)];
      run_instr(op, 30, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
